// File: rtl/cam_pkg.sv
// Shared definitions for the camera capture block: FSM states, RGB565 bit
// positions used by the 3-bit quantiser, and default frame geometry.
package cam_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FRAME = 2'd1,
        HI    = 2'd2,
        LO    = 2'd3
    } cam_state_e;

    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;

    localparam int HI_R_BIT = 7;
    localparam int HI_G_BIT = 2;
    localparam int LO_B_BIT = 4;

    // Keep only the MSB of R and G from the high byte and of B from the low byte.
    function automatic logic [2:0] quantise(input logic [7:0] hi, input logic [7:0] lo);
        return {hi[HI_R_BIT], hi[HI_G_BIT], lo[LO_B_BIT]};
    endfunction

endpackage

// File: rtl/sync_edge.sv
// One-flop sampler with rise/fall detection of the live input against its
// previous sample.
module sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic sig,
    output logic q,
    output logic rise,
    output logic fall
);

    // Previous-cycle sample of the input.
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= 1'b0;
        end else begin
            q <= sig;
        end
    end

    assign rise = sig & ~q;
    assign fall = ~sig & q;

endmodule

// File: rtl/camera_capture.sv
// Captures RGB565 byte pairs from a camera bus, quantises each pixel to 3 bits
// and tracks its column/row, with frame/line framing pulses and error flags.
module camera_capture
    import cam_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF
) (
    input  logic       pclk,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       h_ref,
    input  logic       v_sync,
    output logic       pix_valid,
    output logic [2:0] pix_rgb,
    output logic [9:0] pix_x,
    output logic [8:0] pix_y,
    output logic       frame_start,
    output logic       line_done,
    output logic       frame_done,
    output logic       err_odd,
    output logic       err_long
);

    localparam logic [10:0] H_LIM = 11'(H_ACTIVE);
    localparam logic [9:0]  V_LIM = 10'(V_ACTIVE);

    cam_state_e  state_r, state_next_s;
    logic        v_sync_q, vs_rise_s, vs_fall_s;
    logic        h_ref_q, hr_rise_s, hr_fall_s;
    logic        unused_s;
    logic        start_s, abort_s, latch_s, emit_s, line_end_s, odd_s;
    logic [7:0]  hi_r;
    logic [10:0] x_cnt_r;
    logic [9:0]  y_cnt_r;
    logic        line_px_r;

    sync_edge u_vs_edge (
        .clk   (pclk),
        .reset (reset),
        .sig   (v_sync),
        .q     (v_sync_q),
        .rise  (vs_rise_s),
        .fall  (vs_fall_s)
    );

    sync_edge u_hr_edge (
        .clk   (pclk),
        .reset (reset),
        .sig   (h_ref),
        .q     (h_ref_q),
        .rise  (hr_rise_s),
        .fall  (hr_fall_s)
    );

    // Line framing uses the h_ref level; its edge outputs are not needed here.
    assign unused_s = ^{v_sync_q, h_ref_q, hr_rise_s, hr_fall_s};

    // FSM state register.
    always_ff @(posedge pclk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next state and one-cycle datapath controls; a v_sync rise beats h_ref.
    always_comb begin
        state_next_s = state_r;
        start_s      = 1'b0;
        abort_s      = 1'b0;
        latch_s      = 1'b0;
        emit_s       = 1'b0;
        line_end_s   = 1'b0;
        odd_s        = 1'b0;
        case (state_r)
            IDLE: begin
                if (vs_fall_s) begin
                    state_next_s = FRAME;
                    start_s      = 1'b1;
                end else begin
                    state_next_s = IDLE;
                end
            end
            FRAME: begin
                if (vs_rise_s) begin
                    state_next_s = IDLE;
                    abort_s      = 1'b1;
                end else if (h_ref) begin
                    state_next_s = LO;
                    latch_s      = 1'b1;
                end else begin
                    state_next_s = FRAME;
                end
            end
            HI: begin
                if (vs_rise_s) begin
                    state_next_s = IDLE;
                    abort_s      = 1'b1;
                end else if (h_ref) begin
                    state_next_s = LO;
                    latch_s      = 1'b1;
                end else begin
                    state_next_s = FRAME;
                    line_end_s   = 1'b1;
                end
            end
            LO: begin
                if (vs_rise_s) begin
                    state_next_s = IDLE;
                    abort_s      = 1'b1;
                end else if (h_ref) begin
                    state_next_s = HI;
                    emit_s       = 1'b1;
                end else begin
                    state_next_s = FRAME;
                    line_end_s   = 1'b1;
                    odd_s        = 1'b1;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Pixel datapath, position counters, framing pulses and sticky errors.
    always_ff @(posedge pclk) begin
        if (reset) begin
            pix_valid   <= 1'b0;
            pix_rgb     <= 3'd0;
            pix_x       <= 10'd0;
            pix_y       <= 9'd0;
            frame_start <= 1'b0;
            line_done   <= 1'b0;
            frame_done  <= 1'b0;
            err_odd     <= 1'b0;
            err_long    <= 1'b0;
            hi_r        <= 8'd0;
            x_cnt_r     <= 11'd0;
            y_cnt_r     <= 10'd0;
            line_px_r   <= 1'b0;
        end else begin
            pix_valid   <= 1'b0;
            frame_start <= 1'b0;
            line_done   <= 1'b0;
            frame_done  <= 1'b0;
            if (start_s) begin
                frame_start <= 1'b1;
                pix_y       <= 9'd0;
                y_cnt_r     <= 10'd0;
                x_cnt_r     <= 11'd0;
                line_px_r   <= 1'b0;
                err_odd     <= 1'b0;
                err_long    <= 1'b0;
            end
            if (abort_s) begin
                frame_done <= 1'b1;
                x_cnt_r    <= 11'd0;
                line_px_r  <= 1'b0;
            end
            if (latch_s) begin
                hi_r <= data_in;
            end
            if (emit_s) begin
                if ((x_cnt_r < H_LIM) && (y_cnt_r < V_LIM)) begin
                    pix_valid <= 1'b1;
                    pix_rgb   <= quantise(hi_r, data_in);
                    pix_x     <= x_cnt_r[9:0];
                    pix_y     <= y_cnt_r[8:0];
                    line_px_r <= 1'b1;
                end else begin
                    err_long <= 1'b1;
                end
                // Saturate so an overlong line cannot wrap back into range.
                if (x_cnt_r != H_LIM) begin
                    x_cnt_r <= x_cnt_r + 11'd1;
                end
            end
            if (line_end_s) begin
                line_done <= 1'b1;
                x_cnt_r   <= 11'd0;
                line_px_r <= 1'b0;
                if (line_px_r && (y_cnt_r != V_LIM)) begin
                    y_cnt_r <= y_cnt_r + 10'd1;
                end
                if (odd_s) begin
                    err_odd <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_camera_capture.sv
// Self-checking bench for camera_capture: table-driven pixel vectors plus
// framing corner cases, with a scoreboard queue of expected pixels.
module tb_camera_capture;

    typedef struct packed {
        logic [2:0] rgb;
        logic [9:0] x;
        logic [8:0] y;
    } px_t;

    typedef struct {
        logic [7:0] hi;
        logic [7:0] lo;
        logic [2:0] rgb;
    } vec_t;

    logic       pclk = 1'b0;
    logic       reset;
    logic [7:0] data_in;
    logic       h_ref;
    logic       v_sync;
    logic       pix_valid;
    logic [2:0] pix_rgb;
    logic [9:0] pix_x;
    logic [8:0] pix_y;
    logic       frame_start, line_done, frame_done, err_odd, err_long;

    px_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  n_pix = 0, n_ld = 0, n_fs = 0, n_fd = 0, max_x = 0;

    camera_capture dut (
        .pclk        (pclk),
        .reset       (reset),
        .data_in     (data_in),
        .h_ref       (h_ref),
        .v_sync      (v_sync),
        .pix_valid   (pix_valid),
        .pix_rgb     (pix_rgb),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .frame_start (frame_start),
        .line_done   (line_done),
        .frame_done  (frame_done),
        .err_odd     (err_odd),
        .err_long    (err_long)
    );

    always #5 pclk = ~pclk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard and event counters, sampled mid-cycle.
    always @(negedge pclk) begin
        if (!reset) begin
            if (frame_start) n_fs++;
            if (frame_done)  n_fd++;
            if (line_done)   n_ld++;
            if (pix_valid) begin
                n_pix++;
                if (int'(pix_x) > max_x) max_x = int'(pix_x);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_strobe: got x=%0d y=%0d rgb=%0b expected none", pix_x, pix_y, pix_rgb);
                end else begin
                    px_t e;
                    e = exp_q.pop_front();
                    chk("pixel", 32'({pix_rgb, pix_x, pix_y}), 32'(e));
                end
            end
        end
    end

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic send_pix(input logic [7:0] hi, input logic [7:0] lo, input logic [2:0] rgb,
                            input int x, input int y);
        px_t e;
        if (x < 640 && y < 480) begin
            e.rgb = rgb;
            e.x   = 10'(x);
            e.y   = 9'(y);
            exp_q.push_back(e);
        end
        h_ref   = 1'b1;
        data_in = hi;
        tick();
        data_in = lo;
        tick();
    endtask

    task automatic send_rand_line(input int n, input int y);
        logic [7:0] hi, lo;
        for (int i = 0; i < n; i++) begin
            hi = 8'($urandom);
            lo = 8'($urandom);
            send_pix(hi, lo, {hi[7], hi[2], lo[4]}, i, y);
        end
    endtask

    task automatic end_line();
        h_ref   = 1'b0;
        data_in = 8'h00;
        tick();
        tick();
    endtask

    task automatic start_frame();
        v_sync = 1'b1;
        tick();
        tick();
        v_sync = 1'b0;
        tick();
        tick();
    endtask

    task automatic end_frame();
        h_ref  = 1'b0;
        v_sync = 1'b1;
        tick();
        tick();
    endtask

    vec_t vecs[7];
    int   p0, l0, f0, s0;

    initial begin
        vecs[0] = '{8'hF8, 8'h00, 3'b100};
        vecs[1] = '{8'h07, 8'hE0, 3'b010};
        vecs[2] = '{8'h00, 8'h1F, 3'b001};
        vecs[3] = '{8'hFF, 8'hFF, 3'b111};
        vecs[4] = '{8'h80, 8'h10, 3'b101};
        vecs[5] = '{8'h04, 8'h10, 3'b011};
        vecs[6] = '{8'h7B, 8'hEF, 3'b000};

        reset = 1'b1; data_in = 8'h00; h_ref = 1'b0; v_sync = 1'b0;
        tick(); tick(); tick();
        chk("reset_outputs", 32'({pix_valid, pix_rgb, pix_x, pix_y, frame_start, line_done,
                                  frame_done, err_odd, err_long}), 0);
        reset = 1'b0;
        tick();

        // Basic line of table vectors, one-cycle latency.
        start_frame();
        chk("frame_start_once", n_fs, 1);
        for (int i = 0; i < 7; i++) begin
            send_pix(vecs[i].hi, vecs[i].lo, vecs[i].rgb, i, 0);
            chk("latency_strobe", 32'(pix_valid), 1);
        end
        end_line();
        chk("strobe_one_cycle", 32'(pix_valid), 0);
        chk("hold_x", 32'(pix_x), 6);
        chk("hold_rgb", 32'(pix_rgb), 0);
        chk("line_done_1", n_ld, 1);
        end_frame();
        chk("frame_done_1", n_fd, 1);
        chk("q_empty_1", exp_q.size(), 0);

        // Two full lines.
        p0 = n_pix; l0 = n_ld; f0 = n_fd;
        start_frame();
        send_rand_line(640, 0);
        end_line();
        chk("y_after_line0", 32'(pix_y), 0);
        send_rand_line(640, 1);
        end_line();
        chk("y_after_line1", 32'(pix_y), 1);
        end_frame();
        chk("strobes_1280", n_pix - p0, 1280);
        chk("line_done_2", n_ld - l0, 2);
        chk("frame_done_2", n_fd - f0, 1);
        chk("no_errors", 32'({err_odd, err_long}), 0);
        chk("q_empty_2", exp_q.size(), 0);

        // Overlong line.
        p0 = n_pix; max_x = 0;
        start_frame();
        send_rand_line(641, 0);
        end_line();
        chk("long_strobes", n_pix - p0, 640);
        chk("long_max_x", max_x, 639);
        chk("err_long_set", 32'(err_long), 1);
        send_rand_line(2, 1);
        end_line();
        chk("next_line_x", 32'(pix_x), 1);
        end_frame();
        chk("q_empty_3", exp_q.size(), 0);

        // Odd byte count line.
        p0 = n_pix;
        start_frame();
        chk("err_long_cleared", 32'(err_long), 0);
        send_rand_line(2, 0);
        h_ref = 1'b1; data_in = 8'hAA; tick();
        end_line();
        chk("odd_strobes", n_pix - p0, 2);
        chk("err_odd_set", 32'(err_odd), 1);
        end_frame();
        chk("err_odd_sticky", 32'(err_odd), 1);
        start_frame();
        chk("err_odd_cleared", 32'(err_odd), 0);
        end_frame();
        chk("q_empty_4", exp_q.size(), 0);

        // Reset mid-line, h_ref kept active.
        start_frame();
        send_pix(8'hF8, 8'h00, 3'b100, 0, 0);
        h_ref = 1'b1; data_in = 8'h07; tick();
        p0 = n_pix; s0 = n_fs;
        reset = 1'b1; tick(); tick();
        reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            data_in = 8'(i * 37);
            tick();
        end
        chk("reset_no_strobes", n_pix - p0, 0);
        chk("reset_clears_out", 32'({pix_rgb, pix_x, pix_y, err_odd, err_long}), 0);
        h_ref = 1'b0; tick();
        start_frame();
        chk("restart_frame_start", n_fs - s0, 1);
        send_pix(8'h07, 8'hE0, 3'b010, 0, 0);
        end_line();
        chk("restart_strobes", n_pix - p0, 1);
        end_frame();
        chk("q_empty_5", exp_q.size(), 0);

        // v_sync rise coincident with the high byte.
        start_frame();
        p0 = n_pix; l0 = n_ld; f0 = n_fd; s0 = n_fs;
        v_sync = 1'b1; h_ref = 1'b1; data_in = 8'hF8; tick();
        for (int i = 0; i < 4; i++) begin
            data_in = 8'hFF; tick();
        end
        h_ref = 1'b0; tick(); tick();
        chk("abort_no_strobe", n_pix - p0, 0);
        chk("abort_no_line_done", n_ld - l0, 0);
        chk("abort_frame_done", n_fd - f0, 1);
        v_sync = 1'b0; tick(); tick();
        chk("abort_went_idle", n_fs - s0, 1);
        end_frame();
        chk("q_empty_6", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
